// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if
//   Groups the byte stream coming from the UART receiver with the
//   instruction-memory write port and the boot status outputs.
//
//   Signals:
//     rx_valid    one-cycle strobe, rx_byte valid this cycle
//     rx_byte     received UART byte
//     wr_en       instruction memory write strobe, one cycle per word
//     wr_instr    assembled instruction word, held until the next wr_en
//     load_count  words written since reset
//     boot_done   image fully loaded and accepted
//     boot_err    image rejected
//     cpu_rst_n   active-low CPU reset, released only on boot_done
//
//   Modports:
//     master  byte source / memory side (drives rx_*, observes the rest)
//     slave   the boot loader itself
interface uart_boot_loader_if #(
  parameter int CNT_W = 11
);
  logic             rx_valid;
  logic [7:0]       rx_byte;
  logic             wr_en;
  logic [31:0]      wr_instr;
  logic [CNT_W-1:0] load_count;
  logic             boot_done;
  logic             boot_err;
  logic             cpu_rst_n;

  modport master (
    output rx_valid, rx_byte,
    input  wr_en, wr_instr, load_count, boot_done, boot_err, cpu_rst_n
  );

  modport slave (
    input  rx_valid, rx_byte,
    output wr_en, wr_instr, load_count, boot_done, boot_err, cpu_rst_n
  );
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Sits upstream of the instruction memory bootloader write port. Bytes
//   from the UART receiver are assembled little-endian into 32-bit words.
//   The first word is the image length N (in words); the following N
//   words are written to instruction memory with a one-cycle wr_en each.
//   The CPU is held in reset (cpu_rst_n low) until the whole image has
//   been accepted. A length of zero finishes immediately; a length larger
//   than DEPTH rejects the image.
//
//   Optional feature, macro BOOT_CHECKSUM_EN:
//     after the payload one more word C is received and compared with the
//     XOR of all payload words; a mismatch rejects the image.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    uart_boot_loader_if.slave (rx byte stream, memory write
//            port, load_count, boot_done, boot_err, cpu_rst_n)
//
//   Parameters:
//     DEPTH  instruction memory depth in words (maximum image length)
//     CNT_W  width of load_count, 2**CNT_W must exceed DEPTH
module uart_boot_loader #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    HDR,
    LOAD,
`ifdef BOOT_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t           state;
  logic [1:0]       byte_idx;
  logic [23:0]      asm_word;
  logic [CNT_W-1:0] remaining;
  logic             wr_en_q;
  logic [31:0]      wr_instr_q;
  logic [CNT_W-1:0] load_count_q;
  logic             boot_done_q;
  logic             boot_err_q;
  logic             cpu_rst_n_q;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]      xor_sum;
`endif

  logic             accept;
  logic             word_done;
  logic [31:0]      full_word;

  // Bytes are only taken while a word is still expected. In LOAD the
  // cycle carrying the final wr_en has remaining==0; without the checksum
  // nothing more belongs to the image there, with the checksum that byte
  // is already the first lane of C and must not be dropped.
  always_comb begin
    accept    = 1'b0;
    full_word = {bus.rx_byte, asm_word};
    case (state)
      HDR:  accept = bus.rx_valid;
`ifdef BOOT_CHECKSUM_EN
      LOAD: accept = bus.rx_valid;
      CHK:  accept = bus.rx_valid;
`else
      LOAD: accept = bus.rx_valid && (remaining != '0);
`endif
      default: accept = 1'b0;
    endcase
    word_done = accept && (byte_idx == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HDR;
      byte_idx     <= 2'd0;
      asm_word     <= '0;
      remaining    <= '0;
      wr_en_q      <= 1'b0;
      wr_instr_q   <= '0;
      load_count_q <= '0;
      boot_done_q  <= 1'b0;
      boot_err_q   <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      xor_sum      <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;

      // Lanes 0..2 are buffered; lane 3 is taken straight from rx_byte
      // when the word completes, so it never needs its own register.
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    asm_word[7:0]   <= bus.rx_byte;
          2'd1:    asm_word[15:8]  <= bus.rx_byte;
          2'd2:    asm_word[23:16] <= bus.rx_byte;
          default: ;
        endcase
      end

      case (state)
        HDR: begin
`ifdef BOOT_CHECKSUM_EN
          xor_sum <= '0;
`endif
          if (word_done) begin
            if (full_word == '0) begin
`ifdef BOOT_CHECKSUM_EN
              // An empty image still carries a checksum word, expected 0.
              state <= CHK;
`else
              state       <= DONE;
              boot_done_q <= 1'b1;
              cpu_rst_n_q <= 1'b1;
`endif
            end else if (full_word > 32'(DEPTH)) begin
              state      <= ERR;
              boot_err_q <= 1'b1;
            end else begin
              state     <= LOAD;
              remaining <= full_word[CNT_W-1:0];
            end
          end
        end

        LOAD: begin
          // Leave LOAD on the edge that ends the final wr_en cycle, so the
          // last write is fully visible before the CPU is released.
          if (wr_en_q && (remaining == '0)) begin
`ifdef BOOT_CHECKSUM_EN
            state <= CHK;
`else
            state       <= DONE;
            boot_done_q <= 1'b1;
            cpu_rst_n_q <= 1'b1;
`endif
          end else if (word_done) begin
            wr_instr_q   <= full_word;
            wr_en_q      <= 1'b1;
            load_count_q <= load_count_q + CNT_W'(1);
            remaining    <= remaining - CNT_W'(1);
`ifdef BOOT_CHECKSUM_EN
            xor_sum      <= xor_sum ^ full_word;
`endif
          end
        end

`ifdef BOOT_CHECKSUM_EN
        CHK: begin
          if (word_done) begin
            if (full_word == xor_sum) begin
              state       <= DONE;
              boot_done_q <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end else begin
              state      <= ERR;
              boot_err_q <= 1'b1;
            end
          end
        end
`endif

        // DONE and ERR are terminal; only rst_n starts a new load.
        DONE: ;
        ERR:  ;
        default: begin
          state      <= ERR;
          boot_err_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_instr   = wr_instr_q;
  assign bus.load_count = load_count_q;
  assign bus.boot_done  = boot_done_q;
  assign bus.boot_err   = boot_err_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader
//   Self-checking bench for uart_boot_loader. Byte images are built from
//   word lists by a small reference model (little-endian byte split,
//   length/DEPTH rule, XOR checksum when BOOT_CHECKSUM_EN is defined).
//   A monitor collects every written word and checks the per-cycle
//   invariants; each scenario task checks its own results.
module tb_uart_boot_loader;

  localparam int DEPTH = 1024;
  localparam int CNT_W = 11;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic clk;
  logic rst_n;

  uart_boot_loader_if #(.CNT_W(CNT_W)) bus ();

  uart_boot_loader #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  word_q_t     got_words;
  logic        prev_wr_en = 1'b0;
  logic [31:0] last_word  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: records written words and checks invariants every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr_en = 1'b0;
      last_word  = '0;
    end else begin
      if (bus.wr_en) begin
        got_words.push_back(bus.wr_instr);
        last_word = bus.wr_instr;
        checks++;
        if (bus.load_count !== CNT_W'(got_words.size())) begin
          errors++;
          $display("[TB] FAIL load_count_track: got %0d expected %0d", bus.load_count, got_words.size());
        end
        checks++;
        if (prev_wr_en) begin
          errors++;
          $display("[TB] FAIL wr_en_width: got 2 consecutive cycles expected 1");
        end
      end else begin
        checks++;
        if (bus.wr_instr !== last_word) begin
          errors++;
          $display("[TB] FAIL wr_instr_stable: got %h expected %h", bus.wr_instr, last_word);
        end
      end
      checks++;
      if ((bus.boot_done && bus.boot_err) || (bus.cpu_rst_n !== bus.boot_done)) begin
        errors++;
        $display("[TB] FAIL status_invariant: got done=%b err=%b cpu_rst_n=%b expected cpu_rst_n=done and not both",
                 bus.boot_done, bus.boot_err, bus.cpu_rst_n);
      end
      prev_wr_en = bus.wr_en;
    end
  end

  // Reference model: little-endian image with header and optional checksum.
  function automatic byte_q_t make_image(input logic [31:0] n, input word_q_t words);
    byte_q_t     q;
    logic [31:0] sum = '0;
    for (int k = 0; k < 4; k++) q.push_back(n[8*k +: 8]);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) q.push_back(words[i][8*k +: 8]);
      sum ^= words[i];
    end
`ifdef BOOT_CHECKSUM_EN
    for (int k = 0; k < 4; k++) q.push_back(sum[8*k +: 8]);
`endif
    return q;
  endfunction

  function automatic word_q_t random_words(input int n);
    word_q_t w;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    return w;
  endfunction

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_byte  = '0;
    rst_n        = 1'b0;
    got_words.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called on a negedge; each byte is held for exactly one cycle and
  // returns on the negedge right after the last byte was accepted.
  task automatic send_bytes(input byte_q_t q, input int max_gap);
    int gap;
    foreach (q[i]) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = q[i];
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (bus.boot_done || bus.boot_err) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0;
    bus.rx_byte  = '0;
    rst_n        = 1'b0;
    #3;
    checks++;
    if ({bus.wr_en, bus.wr_instr, bus.load_count, bus.boot_done, bus.boot_err, bus.cpu_rst_n} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got wr_en=%b instr=%h cnt=%0d done=%b err=%b cpu=%b expected all 0",
               bus.wr_en, bus.wr_instr, bus.load_count, bus.boot_done, bus.boot_err, bus.cpu_rst_n);
    end
    do_reset();
    checks++;
    if (bus.cpu_rst_n !== 1'b0 || bus.boot_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got cpu=%b done=%b expected 0 0", bus.cpu_rst_n, bus.boot_done);
    end
  endtask

  task automatic test_two_words();
    word_q_t w = '{32'h0000_0013, 32'h0010_0093};
    byte_q_t hdr_pay = '{8'h02, 8'h00, 8'h00, 8'h00,
                         8'h13, 8'h00, 8'h00, 8'h00,
                         8'h93, 8'h00, 8'h10, 8'h00};
    do_reset();
    send_bytes(hdr_pay, 0);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_instr !== 32'h0010_0093 || bus.boot_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL two_word_last_write: got wr_en=%b instr=%h done=%b expected 1 00100093 0",
               bus.wr_en, bus.wr_instr, bus.boot_done);
    end
    @(negedge clk);
`ifdef BOOT_CHECKSUM_EN
    checks++;
    if (bus.boot_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL two_word_wait_chk: got done=%b expected 0", bus.boot_done);
    end
    send_bytes('{8'h80, 8'h00, 8'h10, 8'h00}, 0);
`endif
    checks++;
    if (bus.boot_done !== 1'b1 || bus.cpu_rst_n !== 1'b1 || bus.boot_err !== 1'b0 ||
        bus.wr_en !== 1'b0 || bus.load_count !== CNT_W'(2)) begin
      errors++;
      $display("[TB] FAIL two_word_done: got done=%b cpu=%b err=%b wr_en=%b cnt=%0d expected 1 1 0 0 2",
               bus.boot_done, bus.cpu_rst_n, bus.boot_err, bus.wr_en, bus.load_count);
    end
    checks++;
    if (got_words.size() != 2 || got_words[0] !== w[0] || got_words[1] !== w[1]) begin
      errors++;
      $display("[TB] FAIL two_word_data: got %0d words expected 2 (00000013 00100093)", got_words.size());
    end
  endtask

  task automatic test_zero_header();
    do_reset();
    send_bytes('{8'h00, 8'h00, 8'h00, 8'h00}, 0);
`ifdef BOOT_CHECKSUM_EN
    checks++;
    if (bus.boot_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_hdr_wait_chk: got done=%b expected 0", bus.boot_done);
    end
    send_bytes('{8'h00, 8'h00, 8'h00, 8'h00}, 0);
`endif
    checks++;
    if (bus.boot_done !== 1'b1 || bus.cpu_rst_n !== 1'b1 || bus.boot_err !== 1'b0 ||
        bus.load_count !== '0 || got_words.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_hdr: got done=%b cpu=%b err=%b cnt=%0d writes=%0d expected 1 1 0 0 0",
               bus.boot_done, bus.cpu_rst_n, bus.boot_err, bus.load_count, got_words.size());
    end
  endtask

  task automatic test_oversize();
    byte_q_t q = '{8'h01, 8'h04, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    do_reset();
    send_bytes(q, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.boot_err !== 1'b1 || bus.boot_done !== 1'b0 || bus.cpu_rst_n !== 1'b0 ||
        got_words.size() != 0 || bus.load_count !== '0) begin
      errors++;
      $display("[TB] FAIL oversize: got err=%b done=%b cpu=%b writes=%0d cnt=%0d expected 1 0 0 0 0",
               bus.boot_err, bus.boot_done, bus.cpu_rst_n, got_words.size(), bus.load_count);
    end
  endtask

  task automatic test_max_depth();
    word_q_t w = random_words(DEPTH);
    bit      to;
    int      bad = 0;
    do_reset();
    send_bytes(make_image(32'(DEPTH), w), 0);
    wait_end(20, to);
    checks++;
    if (to || bus.boot_done !== 1'b1 || bus.load_count !== CNT_W'(DEPTH)) begin
      errors++;
      $display("[TB] FAIL max_depth_done: got timeout=%b done=%b cnt=%0d expected 0 1 %0d",
               to, bus.boot_done, bus.load_count, DEPTH);
    end
    foreach (w[i]) if (i >= got_words.size() || got_words[i] !== w[i]) bad++;
    checks++;
    if (bad != 0 || got_words.size() != DEPTH) begin
      errors++;
      $display("[TB] FAIL max_depth_data: got %0d bad of %0d words expected 0 bad of %0d",
               bad, got_words.size(), DEPTH);
    end
  endtask

  task automatic test_reset_mid_load();
    word_q_t first = random_words(1);
    byte_q_t q     = make_image(32'd2, {first[0], 32'h1234_5678});
    word_q_t w     = '{32'hDEAD_BEEF};
    bit      to;
    do_reset();
    q = q[0:9];
    send_bytes(q, 0);
    checks++;
    if (bus.load_count !== CNT_W'(1) || bus.wr_instr !== first[0]) begin
      errors++;
      $display("[TB] FAIL mid_load_partial: got cnt=%0d instr=%h expected 1 %h",
               bus.load_count, bus.wr_instr, first[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.wr_en, bus.wr_instr, bus.load_count, bus.boot_done, bus.boot_err, bus.cpu_rst_n} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_load_async_reset: got wr_en=%b instr=%h cnt=%0d done=%b err=%b cpu=%b expected all 0",
               bus.wr_en, bus.wr_instr, bus.load_count, bus.boot_done, bus.boot_err, bus.cpu_rst_n);
    end
    @(negedge clk);
    do_reset();
    send_bytes(make_image(32'd1, w), 0);
    wait_end(20, to);
    @(negedge clk);
    checks++;
    if (to || got_words.size() != 1 || got_words[0] !== 32'hDEAD_BEEF ||
        bus.load_count !== CNT_W'(1) || bus.boot_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_load_fresh: got timeout=%b writes=%0d cnt=%0d done=%b expected 0 1 (deadbeef) 1 1",
               to, got_words.size(), bus.load_count, bus.boot_done);
    end
  endtask

  task automatic test_random_gaps();
    word_q_t w = random_words(3);
    word_q_t b2b;
    bit      to;
    int      bad = 0;
    do_reset();
    send_bytes(make_image(32'd3, w), 0);
    wait_end(20, to);
    b2b = got_words;
    checks++;
    if (to || bus.boot_done !== 1'b1 || b2b.size() != 3) begin
      errors++;
      $display("[TB] FAIL gaps_b2b_run: got timeout=%b done=%b writes=%0d expected 0 1 3",
               to, bus.boot_done, b2b.size());
    end
    do_reset();
    send_bytes(make_image(32'd3, w), 20);
    wait_end(50, to);
    foreach (w[i]) begin
      if (i >= got_words.size() || got_words[i] !== w[i]) bad++;
      if (i >= b2b.size() || b2b[i] !== w[i]) bad++;
    end
    checks++;
    if (to || bad != 0 || got_words.size() != 3 || bus.load_count !== CNT_W'(3)) begin
      errors++;
      $display("[TB] FAIL gaps_words: got timeout=%b bad=%0d writes=%0d cnt=%0d expected 0 0 3 3",
               to, bad, got_words.size(), bus.load_count);
    end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum_bad();
    byte_q_t q = '{8'h02, 8'h00, 8'h00, 8'h00,
                   8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    send_bytes(q, 0);
    @(negedge clk);
    checks++;
    if (bus.boot_err !== 1'b1 || bus.boot_done !== 1'b0 || bus.cpu_rst_n !== 1'b0 || got_words.size() != 2) begin
      errors++;
      $display("[TB] FAIL checksum_bad: got err=%b done=%b cpu=%b writes=%0d expected 1 0 0 2",
               bus.boot_err, bus.boot_done, bus.cpu_rst_n, got_words.size());
    end
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = '0;
    @(negedge clk);
    test_reset();
    test_two_words();
    test_zero_header();
    test_oversize();
    test_max_depth();
    test_reset_mid_load();
    test_random_gaps();
`ifdef BOOT_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits directly upstream of the instruction memory's bootloader write port.
- Consumes the byte stream from the UART receiver and assembles bytes into 32-bit little-endian instruction words.
- Drives a one-cycle write strobe plus data word into the instruction memory, which advances its own internal write pointer.
- Holds the CPU core in reset until the full image is loaded, then releases it.

Parameters:
- DEPTH, 1024, instruction memory depth in words; maximum accepted image length.
- CNT_W, 11, width of load_count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_valid  input  1  one-cycle strobe; rx_byte is valid this cycle
- rx_byte  input  8  received UART byte
- wr_en  output  1  instruction memory write strobe, exactly one cycle per word
- wr_instr  output  32  assembled instruction word; stable from its wr_en cycle until the next wr_en
- load_count  output  CNT_W  number of words written since reset
- boot_done  output  1  image fully loaded and accepted
- boot_err  output  1  image rejected
- cpu_rst_n  output  1  active-low reset to CPU core/PC; low until boot_done

Behaviour:
- Reset (async, rst_n low): state=HDR, byte index=0, wr_en=0, wr_instr=0, load_count=0, boot_done=0, boot_err=0, cpu_rst_n=0.
- rx_byte is sampled only on cycles with rx_valid=1. Bytes arriving in DONE or ERR are ignored; only reset restarts a load.
- Byte assembly: a 2-bit byte index selects lane 0..3. Byte 0 goes to [7:0], byte 3 goes to [31:24] (little-endian). After byte 3 the index wraps to 0.
- State HDR: collect 4 bytes into a 32-bit word count N. When byte 3 is accepted:
  - N==0 -> DONE.
  - N>DEPTH -> ERR.
  - Otherwise -> LOAD, with the remaining-word counter set to N.
- State LOAD: collect 4 bytes per word. On the edge that accepts byte 3:
  - wr_instr is loaded with the assembled word.
  - wr_en goes high for exactly the following cycle.
  - load_count increments in the same cycle as wr_en.
  - The remaining-word counter decrements.
- When the remaining count reaches 0 after a write: -> CHK if BOOT_CHECKSUM_EN is defined, else -> DONE. In both cases the transition occurs on the edge after the final wr_en cycle.
- Back-to-back rx_valid on consecutive cycles must be accepted; no bytes are dropped. wr_en may then pulse every 4 cycles at most.
- DONE: boot_done=1 and cpu_rst_n=1 from the first cycle in DONE; both held until reset.
- ERR: boot_err=1, cpu_rst_n stays 0, no further writes.
- boot_done and boot_err are never both 1.
- Latency: the last payload byte is accepted at edge T; wr_en is high during cycle T+1; boot_done is high from T+2 (no checksum).
- Reset mid-load: all state clears immediately. The partially assembled word is discarded and no wr_en is issued.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - A state CHK follows LOAD and collects one further 4-byte little-endian word C.
  - The block keeps a running XOR of all payload words, cleared in HDR.
  - If C equals the running XOR -> DONE; otherwise -> ERR, and cpu_rst_n stays 0.
  - CHK is also entered with N==0, with expected C=0.
- Not defined: no CHK state and no XOR register; LOAD goes straight to DONE.

Test Plan:
- Header 02 00 00 00, payload 13 00 00 00 93 00 10 00 on consecutive-cycle rx_valid -> two wr_en pulses carrying 0x00000013 then 0x00100093; load_count=2; boot_done and cpu_rst_n high 1 cycle after the second wr_en; boot_err=0.
- Header 00 00 00 00 -> no wr_en; boot_done=1 the cycle after the 4th byte (without checksum).
- Header 01 04 00 00 (N=1025 > DEPTH) -> boot_err=1, boot_done=0, cpu_rst_n=0; 8 further bytes produce no wr_en.
- Header for N=1, then 2 payload bytes, then rst_n pulsed low -> outputs return to reset values asynchronously; a fresh load of N=1 word 0xDEADBEEF (EF BE AD DE) yields exactly one wr_en with 0xDEADBEEF and load_count=1.
- Bytes spaced with random 0-20 idle cycles between rx_valid, N=3 -> identical words and order as the back-to-back case; wr_en always exactly one cycle wide.
- BOOT_CHECKSUM_EN defined, words 0x00000013 and 0x00100093:
  - Checksum 80 00 10 00 (0x00100080) -> boot_done=1.
  - Repeat with checksum 00 00 00 00 -> boot_err=1, cpu_rst_n=0.
